// File: rtl/comparador_serial_izq_der.sv
// ---------------------------------------------------------------------------
// comparador_serial_izq_der
//
// Serial unsigned magnitude comparator that scans two N-bit words MSB first,
// one bit per clock. A three-state cell (EQ / GT / LT) is updated each cycle;
// GT and LT are absorbing. The result is registered as one-hot gt/lt/eq
// together with a one-cycle done pulse.
//
// Optional feature (compile-time macro): EARLY_EXIT_EN
//   When defined, the scan stops on the first differing bit and bits_scanned
//   reports how many positions were consumed. Final gt/lt/eq are unchanged.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_start          comparison request, sampled only in IDLE
//   i_a, i_b         operands, captured on the accepted start
//   o_busy           high while the FSM is not IDLE (combinational)
//   o_done           one-cycle pulse while in DONE; results valid
//   o_gt/o_lt/o_eq   registered one-hot comparison result
//   o_bits_scanned   bit positions consumed in the current/last comparison
// ---------------------------------------------------------------------------
module comparador_serial_izq_der #(
    parameter int unsigned N = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [N-1:0]               i_a,
    input  logic [N-1:0]               i_b,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_gt,
    output logic                       o_lt,
    output logic                       o_eq,
    output logic [$clog2(N+1)-1:0]     o_bits_scanned
);

    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // EQ encoded as zero so the reset value is the EQ cell state.
    localparam logic [1:0] CELL_EQ = 2'd0;
    localparam logic [1:0] CELL_GT = 2'd1;
    localparam logic [1:0] CELL_LT = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_sh_a;
    logic [N-1:0]  r_sh_b;
    logic [1:0]    r_cell;
    logic [CW-1:0] r_cnt;
    logic          r_gt;
    logic          r_lt;
    logic          r_eq;
    logic          r_done;

    logic          w_msb_a;
    logic          w_msb_b;
    logic [1:0]    w_cell_nxt;
    logic          w_last;
    logic          w_finish;

    always_comb begin
        w_msb_a    = r_sh_a[N-1];
        w_msb_b    = r_sh_b[N-1];
        w_cell_nxt = r_cell;
        if (r_cell == CELL_EQ) begin
            if (w_msb_a && !w_msb_b) begin
                w_cell_nxt = CELL_GT;
            end else if (!w_msb_a && w_msb_b) begin
                w_cell_nxt = CELL_LT;
            end
        end
        // This edge consumes bit 0.
        w_last = (r_cnt == CW'(N - 1));
`ifdef EARLY_EXIT_EN
        w_finish = w_last || (w_cell_nxt != CELL_EQ);
`else
        w_finish = w_last;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_cell  <= CELL_EQ;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= ST_SCAN;
                        r_sh_a  <= i_a;
                        r_sh_b  <= i_b;
                        r_cell  <= CELL_EQ;
                        r_cnt   <= '0;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_cell <= w_cell_nxt;
                    r_sh_a <= {r_sh_a[N-2:0], 1'b0};
                    r_sh_b <= {r_sh_b[N-2:0], 1'b0};
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_gt    <= (w_cell_nxt == CELL_GT);
                        r_lt    <= (w_cell_nxt == CELL_LT);
                        r_eq    <= (w_cell_nxt == CELL_EQ);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_busy         = (r_state != ST_IDLE);
        o_done         = r_done;
        o_gt           = r_gt;
        o_lt           = r_lt;
        o_eq           = r_eq;
        o_bits_scanned = r_cnt;
    end

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// ---------------------------------------------------------------------------
// Self-checking bench for comparador_serial_izq_der (N = 8), directed vectors.
// Expectations follow the build: EARLY_EXIT_EN changes latency/bits_scanned.
// ---------------------------------------------------------------------------
module tb_comparador_serial_izq_der;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = $clog2(N + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic          gt;
    logic          lt;
    logic          eq;
    logic [CW-1:0] bits_scanned;

    int n_tests = 0;
    int n_fail  = 0;

    comparador_serial_izq_der #(
        .N(N)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_a            (a),
        .i_b            (b),
        .o_busy         (busy),
        .o_done         (done),
        .o_gt           (gt),
        .o_lt           (lt),
        .o_eq           (eq),
        .o_bits_scanned (bits_scanned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept a comparison, wait for done, check results and the return to IDLE.
    task automatic run_cmp(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                           input logic egt, input logic elt, input logic eeq,
                           input int elat, input int ebits);
        int lat;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = '0;
        b = '0;
        chk({tag, " busy_after_t0"}, 32'(busy), 32'd1);
        chk({tag, " eq_cleared"}, 32'(eq), 32'd0);
        lat = 0;
        for (int i = 1; i <= 3 * N; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " gt"}, 32'(gt), 32'(egt));
        chk({tag, " lt"}, 32'(lt), 32'(elt));
        chk({tag, " eq"}, 32'(eq), 32'(eeq));
        chk({tag, " bits"}, 32'(bits_scanned), 32'(ebits));
        @(posedge clk);
        #1;
        chk({tag, " done_falls"}, 32'(done), 32'd0);
        chk({tag, " busy_falls"}, 32'(busy), 32'd0);
        chk({tag, " gt_held"}, 32'(gt), 32'(egt));
        chk({tag, " bits_held"}, 32'(bits_scanned), 32'(ebits));
    endtask

    initial begin
        int ndone;
        int first_lat;
        logic fgt;
        logic flt;
        int p;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst gt", 32'(gt), 32'd0);
        chk("rst lt", 32'(lt), 32'd0);
        chk("rst eq", 32'(eq), 32'd0);
        chk("rst bits", 32'(bits_scanned), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp("a5_a5", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 8, 8);
`ifdef EARLY_EXIT_EN
        run_cmp("80_7f", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1, 1);
`else
        run_cmp("80_7f", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 8, 8);
`endif
        run_cmp("3c_3d", 8'h3C, 8'h3D, 1'b0, 1'b1, 1'b0, 8, 8);

        // start pulsed while busy must be ignored (edge t0+3, or t0+1 with early exit).
`ifdef EARLY_EXIT_EN
        p = 1;
`else
        p = 3;
`endif
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first_lat = 0;
        fgt = 1'b0;
        flt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == p - 1) begin
                start = 1'b1;
                a = 8'h01;
                b = 8'h02;
            end
            if (i == p) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = i + 1;
                    fgt = gt;
                    flt = lt;
                end
            end
        end
        chk("ign done_count", 32'(ndone), 32'd1);
`ifdef EARLY_EXIT_EN
        chk("ign latency", 32'(first_lat), 32'd1);
`else
        chk("ign latency", 32'(first_lat), 32'd8);
`endif
        chk("ign gt", 32'(fgt), 32'd1);
        chk("ign lt", 32'(flt), 32'd0);

        // Asynchronous reset mid-SCAN aborts without a done pulse.
        @(negedge clk);
        a = 8'h55;
        b = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort bits", 32'(bits_scanned), 32'd0);
        chk("abort eq", 32'(eq), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
`ifdef EARLY_EXIT_EN
        run_cmp("10_20", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 3, 3);
`else
        run_cmp("10_20", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8, 8);
`endif

        // start held high, equal words: done every N+2 cycles, one idle cycle between.
        @(negedge clk);
        a = 8'h00;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b done@%0d", i), 32'(done), 32'((i % 10) == 8));
            chk($sformatf("b2b busy@%0d", i), 32'(busy), 32'((i % 10) != 9));
            if (done) chk($sformatf("b2b eq@%0d", i), 32'(eq), 32'd1);
        end
        start = 1'b0;
        repeat (12) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
